// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit definitions for the branch sequencer: T-state encoding,
// the branch opcode, and the strobe bundle decoded from each T-state.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    T_CON  = 3'd1,
    T_PCY  = 3'd2,
    T_ADD  = 3'd3,
    T_PCLD = 3'd4
  } state_t;

  localparam logic [4:0] OPC_BR_CODE = 5'b10010;
  localparam int         OPC_MSB     = 31;
  localparam int         OPC_LSB     = 27;

  typedef struct packed {
    logic gra;
    logic rOut;
    logic conIn;
    logic pcOut;
    logic yIn;
    logic cOut;
    logic aluAdd;
    logic zIn;
    logic zlowOut;
    logic pcIn;
  } strobes_t;

  // pc_in in T_PCLD follows the latched CON result, so a not-taken branch leaves PC alone.
  function automatic strobes_t decodeStrobes(input state_t state, input logic conQ);
    strobes_t s;
    s = '0;
    case (state)
      T_CON: begin
        s.gra   = 1'b1;
        s.rOut  = 1'b1;
        s.conIn = 1'b1;
      end
      T_PCY: begin
        s.pcOut = 1'b1;
        s.yIn   = 1'b1;
      end
      T_ADD: begin
        s.cOut   = 1'b1;
        s.aluAdd = 1'b1;
        s.zIn    = 1'b1;
      end
      T_PCLD: begin
        s.zlowOut = 1'b1;
        s.pcIn    = conQ;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/branch_sequencer_sat_counter.sv
// Saturating up-counter used for the taken / not-taken branch statistics.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (inc && !(&r_count)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/branch_sequencer.sv
// Conditional-branch control sequencer: walks a br instruction through the
// T_CON/T_PCY/T_ADD/T_PCLD datapath steps and loads PC only when CON was set.
module branch_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter logic [4:0] OPC_BR = OPC_BR_CODE,
  parameter int         CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [31:0]      ir,
  input  logic             con,
  input  logic             stall,
  output logic             gra,
  output logic             r_out,
  output logic             con_in,
  output logic             pc_out,
  output logic             y_in,
  output logic             c_out,
  output logic             alu_add,
  output logic             z_in,
  output logic             zlow_out,
  output logic             pc_in,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] nottaken_cnt
);

  state_t   r_state;
  strobes_t r_strobes;
  logic     r_conQ;
  logic     r_done;
  logic     r_illegal;

  state_t   w_nextState;
  logic     w_illegal;
  logic     w_finish;
  logic     w_incTaken;
  logic     w_incNotTaken;
  logic     w_unusedIr;

  // Stall is ignored in IDLE so a start is never lost while the datapath is busy elsewhere.
  always_comb begin
    w_nextState = r_state;
    w_illegal   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (ir[OPC_MSB:OPC_LSB] == OPC_BR) begin
            w_nextState = T_CON;
          end else begin
            w_illegal = 1'b1;
          end
        end
      end
      T_CON:   if (!stall) w_nextState = T_PCY;
      T_PCY:   if (!stall) w_nextState = T_ADD;
      T_ADD:   if (!stall) w_nextState = T_PCLD;
      T_PCLD:  if (!stall) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  assign w_finish      = (r_state == T_PCLD) && !stall;
  assign w_incTaken    = w_finish && r_conQ;
  assign w_incNotTaken = w_finish && !r_conQ;
  assign w_unusedIr    = ^ir[OPC_LSB-1:0];

  // Strobes are decoded from the next state so they line up with the state register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_strobes <= '0;
      r_conQ    <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_strobes <= decodeStrobes(w_nextState, r_conQ);
      r_done    <= w_finish;
      r_illegal <= w_illegal;
      if ((r_state == T_PCY) && !stall) begin
        r_conQ <= con;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_takenCnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (w_incTaken),
    .count   (taken_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_notTakenCnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (w_incNotTaken),
    .count   (nottaken_cnt)
  );

  assign gra      = r_strobes.gra;
  assign r_out    = r_strobes.rOut;
  assign con_in   = r_strobes.conIn;
  assign pc_out   = r_strobes.pcOut;
  assign y_in     = r_strobes.yIn;
  assign c_out    = r_strobes.cOut;
  assign alu_add  = r_strobes.aluAdd;
  assign z_in     = r_strobes.zIn;
  assign zlow_out = r_strobes.zlowOut;
  assign pc_in    = r_strobes.pcIn;
  assign busy     = (r_state != IDLE);
  assign done     = r_done;
  assign illegal  = r_illegal;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed self-checking bench for branch_sequencer (4-bit counters so saturation is reachable).
module tb_branch_sequencer;

  localparam int CNT_W = 4;

  localparam logic [31:0] BR_IR  = 32'h9000_0005;
  localparam logic [31:0] BAD_IR = 32'h1800_0000;

  localparam logic [9:0] S_IDLE   = 10'b00_0000_0000;
  localparam logic [9:0] S_CON    = 10'b11_1000_0000;
  localparam logic [9:0] S_PCY    = 10'b00_0110_0000;
  localparam logic [9:0] S_ADD    = 10'b00_0001_1100;
  localparam logic [9:0] S_PCLD_T = 10'b00_0000_0011;
  localparam logic [9:0] S_PCLD_N = 10'b00_0000_0010;

  logic             clock;
  logic             reset_n;
  logic             start;
  logic [31:0]      ir;
  logic             con;
  logic             stall;
  logic             gra, r_out, con_in, pc_out, y_in;
  logic             c_out, alu_add, z_in, zlow_out, pc_in;
  logic             busy, done, illegal;
  logic [CNT_W-1:0] taken_cnt;
  logic [CNT_W-1:0] nottaken_cnt;
  logic [9:0]       strobes;

  int checkCount = 0;
  int errorCount = 0;

  branch_sequencer #(.CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .ir           (ir),
    .con          (con),
    .stall        (stall),
    .gra          (gra),
    .r_out        (r_out),
    .con_in       (con_in),
    .pc_out       (pc_out),
    .y_in         (y_in),
    .c_out        (c_out),
    .alu_add      (alu_add),
    .z_in         (z_in),
    .zlow_out     (zlow_out),
    .pc_in        (pc_in),
    .busy         (busy),
    .done         (done),
    .illegal      (illegal),
    .taken_cnt    (taken_cnt),
    .nottaken_cnt (nottaken_cnt)
  );

  assign strobes = {gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in, zlow_out, pc_in};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyReset();
    reset_n = 1'b0;
    start   = 1'b0;
    stall   = 1'b0;
    con     = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Runs one br sequence; returns in the done cycle. pokeStart re-asserts start mid-sequence.
  task automatic applyStimulus(input logic conVal, input int stallCycles, input logic pokeStart);
    start = 1'b1;
    ir    = BR_IR;
    tick();
    start = 1'b0;
    checkOutput("tCon", 32'(strobes), 32'(S_CON));
    checkOutput("busyCon", 32'(busy), 32'd1);
    con = conVal;
    tick();
    checkOutput("tPcy", 32'(strobes), 32'(S_PCY));
    if (pokeStart) start = 1'b1;
    tick();
    start = 1'b0;
    con   = ~conVal;
    checkOutput("tAdd", 32'(strobes), 32'(S_ADD));
    for (int i = 0; i < stallCycles; i++) begin
      stall = 1'b1;
      tick();
      checkOutput("tAddStall", 32'(strobes), 32'(S_ADD));
      checkOutput("noDoneStall", 32'(done), 32'd0);
    end
    stall = 1'b0;
    tick();
    checkOutput("tPcld", 32'(strobes), conVal ? 32'(S_PCLD_T) : 32'(S_PCLD_N));
    checkOutput("noDonePcld", 32'(done), 32'd0);
    tick();
    checkOutput("donePulse", 32'(done), 32'd1);
    checkOutput("idleBusy", 32'(busy), 32'd0);
    checkOutput("idleStrobes", 32'(strobes), 32'(S_IDLE));
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    ir      = 32'h0;
    con     = 1'b0;
    stall   = 1'b0;

    // Reset state
    applyReset();
    checkOutput("rstStrobes", 32'(strobes), 32'(S_IDLE));
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstIllegal", 32'(illegal), 32'd0);
    checkOutput("rstTaken", 32'(taken_cnt), 32'd0);

    // 1. Taken branch
    applyStimulus(1'b1, 0, 1'b0);
    checkOutput("t1Taken", 32'(taken_cnt), 32'd1);
    checkOutput("t1NotTaken", 32'(nottaken_cnt), 32'd0);
    tick();
    checkOutput("t1DoneOnce", 32'(done), 32'd0);

    // 2. Not-taken branch
    applyReset();
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("t2NotTaken", 32'(nottaken_cnt), 32'd1);
    checkOutput("t2Taken", 32'(taken_cnt), 32'd0);

    // 3. Illegal opcode
    tick();
    start = 1'b1;
    ir    = BAD_IR;
    tick();
    start = 1'b0;
    checkOutput("t3Illegal", 32'(illegal), 32'd1);
    checkOutput("t3Busy", 32'(busy), 32'd0);
    checkOutput("t3Strobes", 32'(strobes), 32'(S_IDLE));
    tick();
    checkOutput("t3IllegalOnce", 32'(illegal), 32'd0);
    checkOutput("t3BusyAfter", 32'(busy), 32'd0);

    // 4. Stall for three cycles in T_ADD
    applyReset();
    applyStimulus(1'b1, 3, 1'b0);
    checkOutput("t4Taken", 32'(taken_cnt), 32'd1);
    tick();
    checkOutput("t4TakenStable", 32'(taken_cnt), 32'd1);
    checkOutput("t4DoneOnce", 32'(done), 32'd0);

    // 5. Reset during T_ADD
    start = 1'b1;
    ir    = BR_IR;
    con   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checkOutput("t5InAdd", 32'(strobes), 32'(S_ADD));
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checkOutput("t5Strobes", 32'(strobes), 32'(S_IDLE));
    checkOutput("t5Busy", 32'(busy), 32'd0);
    checkOutput("t5Taken", 32'(taken_cnt), 32'd0);
    checkOutput("t5Done", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t5NoPcIn", 32'(pc_in), 32'd0);
      checkOutput("t5StayIdle", 32'(busy), 32'd0);
    end

    // Start and reset in the same cycle: start is lost
    start   = 1'b1;
    ir      = BR_IR;
    reset_n = 1'b0;
    tick();
    start   = 1'b0;
    reset_n = 1'b1;
    checkOutput("rstWinsBusy", 32'(busy), 32'd0);
    tick();
    checkOutput("rstWinsBusy2", 32'(busy), 32'd0);

    // Stall in IDLE does not block acceptance
    stall = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    stall = 1'b0;
    checkOutput("idleStallAccept", 32'(strobes), 32'(S_CON));
    applyReset();

    // 6. Saturation over 17 taken branches; first run pokes start mid-sequence
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 0, (i == 0));
      checkOutput("t6Taken", 32'(taken_cnt), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
      if (i == 0) begin
        tick();
        checkOutput("t6PokeIgnored", 32'(busy), 32'd0);
      end
    end
    checkOutput("t6Saturated", 32'(taken_cnt), 32'hF);
    checkOutput("t6NotTaken", 32'(nottaken_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
